// File: rtl/ps2_key_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix bytes, frame states
// and default timing parameters.
package ps2_key_rx_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int DEF_FILT_CYC    = 8;
   localparam int DEF_TIMEOUT_CYC = 100000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

endpackage

// File: rtl/ps2_filter.sv
// Brings the raw PS/2 pins into the system clock domain, deglitches the
// keyboard clock and emits a one-cycle strobe on each filtered falling edge.
module ps2_filter
   import ps2_key_rx_pkg::*;
#(
   parameter int FILT_CYC = DEF_FILT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall
);

   localparam int CW = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

   logic clk_m;
   logic clk_s;
   logic data_m;
   logic filt;
   logic [CW-1:0] cnt;

   // The counter tracks how long the synchronized clock has disagreed with the
   // filtered level; any return to the old level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_m  <= 1'b1;
         clk_s  <= 1'b1;
         data_m <= 1'b1;
         data_s <= 1'b1;
         filt   <= 1'b1;
         cnt    <= '0;
         fall   <= 1'b0;
      end else begin
         clk_m  <= ps2_clk;
         clk_s  <= clk_m;
         data_m <= ps2_data;
         data_s <= data_m;
         fall   <= 1'b0;
         if (clk_s == filt) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            filt <= clk_s;
            cnt  <= '0;
            fall <= filt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames the serial bit stream, checks parity/stop,
// and folds E0/F0 prefixes into one-cycle key events.
module ps2_key_rx
   import ps2_key_rx_pkg::*;
#(
   parameter int FILT_CYC    = DEF_FILT_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

   logic data_s;
   logic fall;

   rx_state_t state_q;
   rx_state_t state_d;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic par_q;
   logic [TW-1:0] tmo_q;
   logic ext_q;
   logic rel_q;
   logic byte_ok;
   logic bad;
   logic timeout;

   ps2_filter #(
      .FILT_CYC(FILT_CYC)
   ) u_filt (
      .clk     (clk),
      .rst     (rst),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .data_s  (data_s),
      .fall    (fall)
   );

   // A strobe arriving in the same cycle the counter expires still counts as
   // activity, so timeout only fires when no edge is present.
   always_comb begin
      state_d = state_q;
      byte_ok = 1'b0;
      bad     = 1'b0;
      timeout = (state_q != ST_IDLE) && (tmo_q == TMO_MAX) && !fall;
      if (timeout) begin
         state_d = ST_IDLE;
         bad     = 1'b1;
      end else if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!data_s) state_d = ST_DATA;
               else         bad     = 1'b1;
            end
            ST_DATA: begin
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
               state_d = ST_IDLE;
               if (data_s && (^{shift_q, par_q})) byte_ok = 1'b1;
               else                               bad     = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         ext_q       <= 1'b0;
         rel_q       <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_ext     <= 1'b0;
         key_release <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_valid <= 1'b0;
         frame_err <= bad;

         if (state_q == ST_IDLE || fall) tmo_q <= '0;
         else                            tmo_q <= tmo_q + 1'b1;

         if (fall) begin
            case (state_q)
               ST_IDLE: bit_cnt_q <= '0;
               ST_DATA: begin
                  shift_q   <= {data_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               ST_PARITY: par_q <= data_s;
               default: ;
            endcase
         end

         if (bad) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
         end

         // Prefix bytes only arm the flags; every other byte is a key event.
         if (byte_ok) begin
            if (shift_q == PS2_EXT) begin
               ext_q <= 1'b1;
            end else if (shift_q == PS2_BRK) begin
               rel_q <= 1'b1;
            end else begin
               key_code    <= shift_q;
               key_ext     <= ext_q;
               key_release <= rel_q;
               key_valid   <= 1'b1;
               ext_q       <= 1'b0;
               rel_q       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames and compares every
// key_valid/frame_err event against a queue of expected events.
module tb_ps2_key_rx;

   localparam int FILT = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   logic key_valid;
   logic [7:0] key_code;
   logic key_ext;
   logic key_release;
   logic frame_err;

   typedef struct packed {
      logic       is_err;
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } exp_t;

   exp_t exp_q[$];
   int errors = 0;
   int checks = 0;
   int events = 0;
   int pushed = 0;

   ps2_key_rx #(
      .FILT_CYC   (FILT),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_release(key_release),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic apply_stimulus(input logic [7:0] b, input logic par_flip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ par_flip);
      send_bit(stop);
      ps2_data = 1'b1;
      wait_cycles(2 * HALF);
   endtask

   task automatic expect_key(input logic [7:0] code, input logic ext, input logic rel);
      exp_q.push_back('{is_err: 1'b0, code: code, ext: ext, rel: rel});
      pushed++;
   endtask

   task automatic expect_err();
      exp_q.push_back('{is_err: 1'b1, code: 8'h00, ext: 1'b0, rel: 1'b0});
      pushed++;
   endtask

   // Scoreboard side: every output event must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (key_valid === 1'b1 || frame_err === 1'b1)) begin
         events++;
         check_output("exclusive", {31'd0, key_valid & frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            check_output("unexpected_event", {30'd0, key_valid, frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_output("event_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
            if (!e.is_err) begin
               check_output("key_code", {24'd0, key_code}, {24'd0, e.code});
               check_output("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
               check_output("key_release", {31'd0, key_release}, {31'd0, e.rel});
            end
         end
      end
   end

   initial begin
      $display("[TB] start");
      wait_cycles(5);
      check_output("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_output("rst_key_code", {24'd0, key_code}, 32'd0);
      check_output("rst_key_ext", {31'd0, key_ext}, 32'd0);
      check_output("rst_key_release", {31'd0, key_release}, 32'd0);
      rst = 1'b0;
      wait_cycles(20);

      // 0x1C with exact stop-bit latency: pin fall + 2 sync + FILT filter + 1 register.
      expect_key(8'h1C, 1'b0, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'(8'h1C >> i));
      send_bit(1'b0);
      ps2_data = 1'b1;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      repeat (11) @(negedge clk);
      check_output("latency_before", {31'd0, key_valid}, 32'd0);
      @(negedge clk);
      check_output("latency_at", {31'd0, key_valid}, 32'd1);
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      wait_cycles(2 * HALF);

      // Break code, then a plain make code must not inherit the release flag.
      apply_stimulus(8'hF0, 1'b0, 1'b1);
      expect_key(8'h1C, 1'b0, 1'b1);
      apply_stimulus(8'h1C, 1'b0, 1'b1);
      expect_key(8'h1C, 1'b0, 1'b0);
      apply_stimulus(8'h1C, 1'b0, 1'b1);

      // Extended break.
      apply_stimulus(8'hE0, 1'b0, 1'b1);
      apply_stimulus(8'hF0, 1'b0, 1'b1);
      expect_key(8'h75, 1'b1, 1'b1);
      apply_stimulus(8'h75, 1'b0, 1'b1);

      // Parity error, then recovery.
      expect_err();
      apply_stimulus(8'h1C, 1'b1, 1'b1);
      expect_key(8'h29, 1'b0, 1'b0);
      apply_stimulus(8'h29, 1'b0, 1'b1);

      // Stop bit error after an F0 prefix: the flag must be dropped.
      apply_stimulus(8'hF0, 1'b0, 1'b1);
      expect_err();
      apply_stimulus(8'h5A, 1'b0, 1'b0);
      expect_key(8'h5A, 1'b0, 1'b0);
      apply_stimulus(8'h5A, 1'b0, 1'b1);

      // Timeout mid-frame after an E0 prefix.
      apply_stimulus(8'hE0, 1'b0, 1'b1);
      expect_err();
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'(8'h29 >> i));
      wait_cycles(TMO + 10 + HALF);
      ps2_data = 1'b1;
      wait_cycles(2 * HALF);
      expect_key(8'h29, 1'b0, 1'b0);
      apply_stimulus(8'h29, 1'b0, 1'b1);

      // A short glitch while idle must be ignored entirely.
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(100);

      // A falling edge with data high is a bad start bit.
      expect_err();
      send_bit(1'b1);
      wait_cycles(2 * HALF);

      // Reset in the middle of a frame clears all outputs and state.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(8'h33 >> i));
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      #4;
      check_output("midrst_key_valid", {31'd0, key_valid}, 32'd0);
      check_output("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      check_output("midrst_key_code", {24'd0, key_code}, 32'd0);
      check_output("midrst_key_ext", {31'd0, key_ext}, 32'd0);
      check_output("midrst_key_release", {31'd0, key_release}, 32'd0);
      ps2_data = 1'b1;
      wait_cycles(2 * HALF);
      expect_key(8'h1C, 1'b0, 1'b0);
      apply_stimulus(8'h1C, 1'b0, 1'b1);

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
      wait_cycles(10);
      check_output("queue_drained", exp_q.size(), 32'd0);
      check_output("event_count", events, pushed);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
